// File: rtl/ifu_if.sv
// Fetch unit bus bundle: redirect input, instruction-memory request/response
// channel and the decode-side valid/ready handshake.
interface ifu_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  i_exu_jmp_en;
   logic [ADDR_WIDTH-1:0] i_exu_jmp_pc;
   logic                  o_ifu_mem_req_valid;
   logic                  i_ifu_mem_req_ready;
   logic [ADDR_WIDTH-1:0] o_ifu_mem_addr;
   logic                  i_ifu_mem_rsp_valid;
   logic [DATA_WIDTH-1:0] i_ifu_mem_rsp_data;
   logic                  o_sys_valid;
   logic                  i_sys_ready;
   logic [ADDR_WIDTH-1:0] o_ifu_pc;
   logic [DATA_WIDTH-1:0] o_ifu_inst;

   // fetch unit side
   modport master (
      input  i_exu_jmp_en, i_exu_jmp_pc, i_ifu_mem_req_ready,
             i_ifu_mem_rsp_valid, i_ifu_mem_rsp_data, i_sys_ready,
      output o_ifu_mem_req_valid, o_ifu_mem_addr, o_sys_valid,
             o_ifu_pc, o_ifu_inst
   );

   // environment side (execute stage, memory, decode)
   modport slave (
      output i_exu_jmp_en, i_exu_jmp_pc, i_ifu_mem_req_ready,
             i_ifu_mem_rsp_valid, i_ifu_mem_rsp_data, i_sys_ready,
      input  o_ifu_mem_req_valid, o_ifu_mem_addr, o_sys_valid,
             o_ifu_pc, o_ifu_inst
   );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding fetch at a time, REQ -> WAIT -> HOLD.
// A redirect from execute discards in-flight work; a response that was already
// requested before the redirect is drained and dropped via the flush flag.
module ifu #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
   input  logic  i_sys_clk,
   input  logic  i_sys_rst,
   ifu_if.master bus
);

   typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] pc, pc_nxt;
   logic [DATA_WIDTH-1:0] inst, inst_nxt;
   logic                  flush, flush_nxt;
   logic                  req_valid, sys_valid;
   logic [ADDR_WIDTH-1:0] tgt;

   // redirect targets are always word aligned
   assign tgt = {bus.i_exu_jmp_pc[ADDR_WIDTH-1:2], 2'b00};

   // state and architectural registers
   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state <= REQ;
         pc    <= RESET_PC;
         inst  <= '0;
         flush <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         inst  <= inst_nxt;
         flush <= flush_nxt;
      end
   end

   // next-state and handshake outputs; a redirect always suppresses both valids
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      inst_nxt  = inst;
      flush_nxt = flush;
      req_valid = 1'b0;
      sys_valid = 1'b0;
      unique case (state)
         REQ: begin
            req_valid = !bus.i_exu_jmp_en;
            if (bus.i_exu_jmp_en)           pc_nxt    = tgt;
            else if (bus.i_ifu_mem_req_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.i_ifu_mem_rsp_valid) begin
               if (flush || bus.i_exu_jmp_en) begin
                  // stale or pre-empted response: drop it and refetch
                  flush_nxt = 1'b0;
                  if (bus.i_exu_jmp_en) pc_nxt = tgt;
                  state_nxt = REQ;
               end else begin
                  inst_nxt  = bus.i_ifu_mem_rsp_data;
                  state_nxt = HOLD;
               end
            end else if (bus.i_exu_jmp_en) begin
               // response still owed by memory; remember to discard it
               pc_nxt    = tgt;
               flush_nxt = 1'b1;
            end
         end
         HOLD: begin
            sys_valid = !bus.i_exu_jmp_en;
            if (bus.i_exu_jmp_en) begin
               pc_nxt    = tgt;
               state_nxt = REQ;
            end else if (bus.i_sys_ready) begin
               pc_nxt    = pc + ADDR_WIDTH'(4);
               state_nxt = REQ;
            end
         end
         default: state_nxt = REQ;
      endcase
   end

   // valids are masked combinationally so reset drops them without waiting for a clock
   assign bus.o_ifu_mem_req_valid = req_valid & ~i_sys_rst;
   assign bus.o_sys_valid         = sys_valid & ~i_sys_rst;
   assign bus.o_ifu_mem_addr      = pc;
   assign bus.o_ifu_pc            = pc;
   assign bus.o_ifu_inst          = inst;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus a randomized run
// checked against a transaction-level model of the expected PC stream.
module tb_ifu;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   logic clk, rst, rst2;
   int   n_cmp, n_bad;

   // memory responder controls
   bit   mem_rand;
   int   fixed_lat;
   int   rsp_cnt;
   logic [31:0] rsp_addr;

   ifu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   ifu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

   ifu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
      .i_sys_clk(clk), .i_sys_rst(rst), .bus(bus));
   ifu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(WRAP_PC)) dut_wrap (
      .i_sys_clk(clk), .i_sys_rst(rst2), .bus(bus2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // memory model: one outstanding request, response 1..3 cycles after acceptance
   initial begin
      rsp_cnt = 0;
      rsp_addr = '0;
      forever begin
         @(negedge clk);
         if (!rst && bus.o_ifu_mem_req_valid && bus.i_ifu_mem_req_ready) begin
            rsp_addr = bus.o_ifu_mem_addr;
            rsp_cnt  = mem_rand ? int'($urandom_range(1, 3)) : fixed_lat;
         end
         @(posedge clk);
         #1;
         bus.i_ifu_mem_rsp_valid = 1'b0;
         if (rst) rsp_cnt = 0;
         else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               bus.i_ifu_mem_rsp_valid = 1'b1;
               bus.i_ifu_mem_rsp_data  = mem_f(rsp_addr);
            end
         end
         bus.i_ifu_mem_req_ready = mem_rand ? 1'($urandom % 2) : 1'b1;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.i_exu_jmp_en = 1'b0;
      bus.i_sys_ready  = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if (bus.o_ifu_mem_req_valid !== 1'b0 || bus.o_sys_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_valids: got req=%b sys=%b want 0/0", bus.o_ifu_mem_req_valid, bus.o_sys_valid);
      end
      // a redirect during reset must not move the PC
      bus.i_exu_jmp_en = 1'b1;
      bus.i_exu_jmp_pc = 32'h1234_5678;
      step();
      @(negedge clk);
      n_cmp++;
      if (bus.o_ifu_pc !== RST_PC || bus.o_ifu_inst !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_regs: got pc=%h inst=%h want %h/0", bus.o_ifu_pc, bus.o_ifu_inst, RST_PC);
      end
      step();
      bus.i_exu_jmp_en = 1'b0;
      rst = 1'b0;
   endtask

   // memory always ready, 1-cycle response, decode always ready: 3-cycle cadence
   task automatic test_stream();
      logic [31:0] a;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) step();
         @(negedge clk);
         a = RST_PC + 32'(4 * (c / 3));
         n_cmp++;
         if (bus.o_ifu_mem_req_valid !== (c % 3 == 0) || bus.o_sys_valid !== (c % 3 == 2)) begin
            n_bad++;
            $display("FAIL stream_valids c=%0d: got req=%b sys=%b", c, bus.o_ifu_mem_req_valid, bus.o_sys_valid);
         end
         if (c % 3 == 0) begin
            n_cmp++;
            if (bus.o_ifu_mem_addr !== a) begin
               n_bad++;
               $display("FAIL stream_addr c=%0d: got %h want %h", c, bus.o_ifu_mem_addr, a);
            end
         end
         if (c % 3 == 2) begin
            n_cmp++;
            if (bus.o_ifu_pc !== a || bus.o_ifu_inst !== mem_f(a)) begin
               n_bad++;
               $display("FAIL stream_out c=%0d: got pc=%h inst=%h want %h/%h", c, bus.o_ifu_pc, bus.o_ifu_inst, a, mem_f(a));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] p0, i0;
      bit found = 0;
      step();
      bus.i_sys_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) step();
         @(negedge clk);
         if (bus.o_sys_valid) begin found = 1; break; end
      end
      n_cmp++;
      if (!found || bus.o_ifu_pc !== 32'h8000_000C || bus.o_ifu_inst !== mem_f(32'h8000_000C)) begin
         n_bad++;
         $display("FAIL bp_first: found=%0d pc=%h want 8000000c", found, bus.o_ifu_pc);
      end
      p0 = bus.o_ifu_pc;
      i0 = bus.o_ifu_inst;
      for (int k = 0; k < 5; k++) begin
         step();
         @(negedge clk);
         n_cmp++;
         if (bus.o_sys_valid !== 1'b1 || bus.o_ifu_pc !== p0 || bus.o_ifu_inst !== i0 ||
             bus.o_ifu_mem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold k=%0d: sys=%b pc=%h inst=%h req=%b want 1/%h/%h/0",
                     k, bus.o_sys_valid, bus.o_ifu_pc, bus.o_ifu_inst, bus.o_ifu_mem_req_valid, p0, i0);
         end
      end
      step();
      bus.i_sys_ready = 1'b1;
      step();
      @(negedge clk);
      n_cmp++;
      if (bus.o_ifu_mem_req_valid !== 1'b1 || bus.o_ifu_mem_addr !== p0 + 32'd4) begin
         n_bad++;
         $display("FAIL bp_advance: got req=%b addr=%h want 1/%h", bus.o_ifu_mem_req_valid, bus.o_ifu_mem_addr, p0 + 32'd4);
      end
   endtask

   task automatic test_redirect_wait();
      bit found = 0;
      mem_rand  = 0;
      fixed_lat = 3;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         if (i > 0) step();
         @(negedge clk);
         if (bus.o_ifu_mem_req_valid && bus.i_ifu_mem_req_ready &&
             bus.o_ifu_mem_addr == 32'h8000_0004) begin found = 1; break; end
      end
      step();
      bus.i_exu_jmp_en = 1'b1;
      bus.i_exu_jmp_pc = 32'h8000_0103;
      @(negedge clk);
      n_cmp++;
      if (!found || bus.o_sys_valid !== 1'b0 || bus.o_ifu_mem_req_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rw_jump: found=%0d sys=%b req=%b", found, bus.o_sys_valid, bus.o_ifu_mem_req_valid);
      end
      step();
      bus.i_exu_jmp_en = 1'b0;
      found = 0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) step();
         @(negedge clk);
         if (bus.o_sys_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rw_drop: got sys_valid=1 pc=%h want 0", bus.o_ifu_pc);
         end
         if (bus.o_ifu_mem_req_valid) begin found = 1; break; end
      end
      n_cmp++;
      if (!found || bus.o_ifu_mem_addr !== 32'h8000_0100) begin
         n_bad++;
         $display("FAIL rw_target: found=%0d addr=%h want 80000100", found, bus.o_ifu_mem_addr);
      end
   endtask

   task automatic test_redirect_coincident();
      mem_rand  = 0;
      fixed_lat = 1;
      do_reset();
      @(negedge clk);
      n_cmp++;
      if (bus.o_ifu_mem_req_valid !== 1'b1 || bus.o_ifu_mem_addr !== RST_PC) begin
         n_bad++;
         $display("FAIL rc_first: req=%b addr=%h want 1/%h", bus.o_ifu_mem_req_valid, bus.o_ifu_mem_addr, RST_PC);
      end
      step();  // WAIT with response present
      bus.i_exu_jmp_en = 1'b1;
      bus.i_exu_jmp_pc = 32'h8000_0200;
      @(negedge clk);
      n_cmp++;
      if (bus.o_sys_valid !== 1'b0 || bus.o_ifu_mem_req_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rc_wait_valids: sys=%b req=%b want 0/0", bus.o_sys_valid, bus.o_ifu_mem_req_valid);
      end
      step();
      bus.i_exu_jmp_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.o_ifu_mem_req_valid !== 1'b1 || bus.o_ifu_mem_addr !== 32'h8000_0200 || bus.o_ifu_inst !== 32'h0) begin
         n_bad++;
         $display("FAIL rc_wait_next: req=%b addr=%h inst=%h want 1/80000200/0",
                  bus.o_ifu_mem_req_valid, bus.o_ifu_mem_addr, bus.o_ifu_inst);
      end
      step();  // WAIT
      step();  // HOLD: redirect together with ready
      bus.i_exu_jmp_en = 1'b1;
      bus.i_exu_jmp_pc = 32'h8000_0200;
      bus.i_sys_ready  = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.o_sys_valid !== 1'b0 || bus.o_ifu_inst !== mem_f(32'h8000_0200)) begin
         n_bad++;
         $display("FAIL rc_hold: sys=%b inst=%h want 0/%h", bus.o_sys_valid, bus.o_ifu_inst, mem_f(32'h8000_0200));
      end
      step();
      bus.i_exu_jmp_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.o_ifu_mem_req_valid !== 1'b1 || bus.o_ifu_mem_addr !== 32'h8000_0200) begin
         n_bad++;
         $display("FAIL rc_hold_next: req=%b addr=%h want 1/80000200", bus.o_ifu_mem_req_valid, bus.o_ifu_mem_addr);
      end
   endtask

   task automatic test_redirect_req();
      mem_rand = 0;
      do_reset();
      bus.i_exu_jmp_en = 1'b1;
      bus.i_exu_jmp_pc = 32'h8000_0040;
      @(negedge clk);
      n_cmp++;
      if (bus.o_ifu_mem_req_valid !== 1'b0 || bus.i_ifu_mem_req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rq_suppress: req=%b want 0", bus.o_ifu_mem_req_valid);
      end
      step();
      bus.i_exu_jmp_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.o_ifu_mem_req_valid !== 1'b1 || bus.o_ifu_mem_addr !== 32'h8000_0040) begin
         n_bad++;
         $display("FAIL rq_target: req=%b addr=%h want 1/80000040", bus.o_ifu_mem_req_valid, bus.o_ifu_mem_addr);
      end
   endtask

   task automatic test_wrap();
      step();
      rst2 = 1'b0;
      bus2.i_ifu_mem_req_ready = 1'b1;
      bus2.i_sys_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus2.o_ifu_mem_req_valid !== 1'b1 || bus2.o_ifu_mem_addr !== WRAP_PC) begin
         n_bad++;
         $display("FAIL wrap_first: req=%b addr=%h want 1/%h", bus2.o_ifu_mem_req_valid, bus2.o_ifu_mem_addr, WRAP_PC);
      end
      step();
      bus2.i_ifu_mem_rsp_valid = 1'b1;
      bus2.i_ifu_mem_rsp_data  = mem_f(WRAP_PC);
      step();
      bus2.i_ifu_mem_rsp_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus2.o_sys_valid !== 1'b1 || bus2.o_ifu_pc !== WRAP_PC || bus2.o_ifu_inst !== mem_f(WRAP_PC)) begin
         n_bad++;
         $display("FAIL wrap_out: sys=%b pc=%h inst=%h", bus2.o_sys_valid, bus2.o_ifu_pc, bus2.o_ifu_inst);
      end
      step();
      @(negedge clk);
      n_cmp++;
      if (bus2.o_ifu_mem_req_valid !== 1'b1 || bus2.o_ifu_mem_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL wrap_next: req=%b addr=%h want 1/00000000", bus2.o_ifu_mem_req_valid, bus2.o_ifu_mem_addr);
      end
   endtask

   task automatic test_reset_async();
      bit found = 0;
      mem_rand  = 0;
      fixed_lat = 3;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         if (i > 0) step();
         @(negedge clk);
         if (bus.o_ifu_mem_req_valid && bus.o_ifu_mem_addr == 32'h8000_0004) begin found = 1; break; end
      end
      step();  // WAIT, pc = 8000_0004
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (!found || bus.o_ifu_mem_req_valid !== 1'b0 || bus.o_sys_valid !== 1'b0 || bus.o_ifu_pc !== RST_PC) begin
         n_bad++;
         $display("FAIL ar_wait: found=%0d req=%b sys=%b pc=%h", found, bus.o_ifu_mem_req_valid, bus.o_sys_valid, bus.o_ifu_pc);
      end
      for (int i = 0; i < 4; i++) step();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.o_ifu_mem_req_valid !== 1'b1 || bus.o_ifu_mem_addr !== RST_PC || bus.o_sys_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL ar_restart: req=%b addr=%h sys=%b", bus.o_ifu_mem_req_valid, bus.o_ifu_mem_addr, bus.o_sys_valid);
      end
      // reset in HOLD drops sys_valid before any clock edge
      bus.i_sys_ready = 1'b0;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         @(negedge clk);
         if (bus.o_sys_valid) begin found = 1; break; end
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if (!found || bus.o_sys_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL ar_hold: found=%0d sys=%b want 0", found, bus.o_sys_valid);
      end
      step();
      rst = 1'b0;
      bus.i_sys_ready = 1'b1;
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      int xfers = 0;
      mem_rand = 1;
      do_reset();
      exp_pc = RST_PC;
      for (int i = 0; i < 3000; i++) begin
         if (i > 0) step();
         bus.i_sys_ready  = 1'($urandom % 2);
         bus.i_exu_jmp_en = ($urandom % 12 == 0);
         bus.i_exu_jmp_pc = $urandom;
         @(negedge clk);
         if (bus.i_exu_jmp_en) begin
            n_cmp++;
            if (bus.o_sys_valid !== 1'b0 || bus.o_ifu_mem_req_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL rand_jmp_valids i=%0d: sys=%b req=%b", i, bus.o_sys_valid, bus.o_ifu_mem_req_valid);
            end
            exp_pc = {bus.i_exu_jmp_pc[31:2], 2'b00};
         end else begin
            if (bus.o_ifu_mem_req_valid && bus.i_ifu_mem_req_ready) begin
               n_cmp++;
               if (bus.o_ifu_mem_addr !== exp_pc) begin
                  n_bad++;
                  $display("FAIL rand_addr i=%0d: got %h want %h", i, bus.o_ifu_mem_addr, exp_pc);
               end
            end
            if (bus.o_sys_valid) begin
               n_cmp++;
               if (bus.o_ifu_pc !== exp_pc || bus.o_ifu_inst !== mem_f(exp_pc)) begin
                  n_bad++;
                  $display("FAIL rand_out i=%0d: got pc=%h inst=%h want %h/%h",
                           i, bus.o_ifu_pc, bus.o_ifu_inst, exp_pc, mem_f(exp_pc));
               end
               if (bus.i_sys_ready) begin
                  exp_pc += 32'd4;
                  xfers++;
               end
            end
         end
      end
      n_cmp++;
      if (xfers < 50) begin
         n_bad++;
         $display("FAIL rand_progress: got %0d transfers want >= 50", xfers);
      end
      mem_rand = 0;
      bus.i_exu_jmp_en = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      mem_rand = 0;
      fixed_lat = 1;
      rst = 1'b1;
      rst2 = 1'b1;
      bus.i_exu_jmp_en = 1'b0;
      bus.i_exu_jmp_pc = '0;
      bus.i_ifu_mem_req_ready = 1'b1;
      bus.i_ifu_mem_rsp_valid = 1'b0;
      bus.i_ifu_mem_rsp_data  = '0;
      bus.i_sys_ready = 1'b1;
      bus2.i_exu_jmp_en = 1'b0;
      bus2.i_exu_jmp_pc = '0;
      bus2.i_ifu_mem_req_ready = 1'b1;
      bus2.i_ifu_mem_rsp_valid = 1'b0;
      bus2.i_ifu_mem_rsp_data  = '0;
      bus2.i_sys_ready = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_coincident();
      test_redirect_req();
      test_wrap();
      test_reset_async();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: the front end that feeds the decode stage and acts on the jump/branch redirect (`jmp_en`, `jmp_pc`) produced by the execute stage. It holds the architectural PC and issues one instruction-memory request at a time over a valid/ready request channel with a valid-only response channel. It presents the fetched instruction downstream over the `o_sys_valid`/`i_sys_ready` handshake. A redirect discards in-flight work and restarts fetch at the target.

## Interface
- `ADDR_WIDTH`, 32, PC / memory address width
- `DATA_WIDTH`, 32, instruction width
- `RESET_PC`, 32'h8000_0000, PC after reset
- One clock; reset is asynchronous and active-high.
- `i_sys_clk`  in  1  clock
- `i_sys_rst`  in  1  asynchronous active-high reset
- `i_exu_jmp_en`  in  1  redirect request, valid for one cycle
- `i_exu_jmp_pc`  in  ADDR_WIDTH  redirect target
- `o_ifu_mem_req_valid`  out  1  fetch request valid
- `i_ifu_mem_req_ready`  in  1  memory accepts request
- `o_ifu_mem_addr`  out  ADDR_WIDTH  fetch address (= PC)
- `i_ifu_mem_rsp_valid`  in  1  response data valid
- `i_ifu_mem_rsp_data`  in  DATA_WIDTH  fetched instruction
- `o_sys_valid`  out  1  instruction valid to decode
- `i_sys_ready`  in  1  decode accepts instruction
- `o_ifu_pc`  out  ADDR_WIDTH  PC of presented instruction
- `o_ifu_inst`  out  DATA_WIDTH  presented instruction (registered)

## Operation
- Registers: `pc`, `inst`, `flush`, `state` ∈ {REQ, WAIT, HOLD}.
- Reset: state=REQ, pc=RESET_PC, inst=0, flush=0.
- Redirect target is forced 4-byte aligned: `pc <= {i_exu_jmp_pc[ADDR_WIDTH-1:2], 2'b00}`.
- REQ: `o_ifu_mem_req_valid = !i_exu_jmp_en`. `o_ifu_mem_addr = pc`.
  - Redirect: pc <= target; stay in REQ. No request is issued that cycle.
  - Otherwise, when `req_valid && req_ready`, go to WAIT.
- WAIT: no request is issued.
  - Redirect without `rsp_valid`: pc <= target, flush <= 1, stay in WAIT. A later redirect overwrites pc again.
  - `rsp_valid` with flush=1, or with a redirect in the same cycle: the response is discarded, flush <= 0, pc <= target (if a redirect is present), go to REQ.
  - `rsp_valid` with flush=0 and no redirect: inst <= rsp_data, go to HOLD.
- HOLD: `o_sys_valid = !i_exu_jmp_en`.
  - Redirect: pc <= target, go to REQ. This wins over `i_sys_ready`, so the held instruction is not transferred.
  - Otherwise, when `i_sys_ready`: pc <= pc + 4 (wraps modulo 2^ADDR_WIDTH), go to REQ.
- `o_sys_valid` = 0 and `o_ifu_mem_req_valid` = 0 in REQ/WAIT and HOLD respectively. Both are 0 while `i_sys_rst` is high.
- `o_ifu_pc = pc`; `o_ifu_inst = inst`. Both are stable for the whole of HOLD.
- `o_ifu_mem_addr` stays stable while a request is pending (REQ without redirect).
- Responses arriving in REQ or HOLD violate the protocol and are ignored.

## Timing
- Memory contract: at most one outstanding request. A response arrives no earlier than the cycle after acceptance.
- Best case, request accepted in cycle N:
  - response in N+1;
  - `o_sys_valid` high in N+2;
  - if ready is high in N+2, the next request is issued in N+3.
- Throughput is one instruction per 3 cycles at best; there is no pipelining.
- A redirect at cycle N takes effect on the registers at edge N+1. The first request to the target is issued in N+1 when in REQ/HOLD. When in WAIT, it is issued the cycle after the flushed response.
- Asynchronous reset at any point drops both valids immediately; pending responses are ignored after reset. Release takes effect on the next clock edge.

## Test plan
- Reset release, memory always ready, 1-cycle response, decode always ready:
  - requests go to 0x8000_0000, 0x8000_0004, 0x8000_0008;
  - `o_sys_valid` pulses every 3 cycles;
  - `o_ifu_pc`/`o_ifu_inst` match the memory model.
- Decode backpressure: `i_sys_ready` held low for 5 cycles in HOLD.
  - `o_sys_valid`, `o_ifu_pc` and `o_ifu_inst` stay constant.
  - No memory request is issued.
  - The PC advances only after ready rises.
- Redirect in WAIT: `jmp_pc`=0x8000_0103 while a fetch of 0x8000_0004 is outstanding.
  - That response is dropped and `o_sys_valid` stays 0.
  - The next request is to 0x8000_0100.
- Redirect coincident with `rsp_valid` in WAIT, and redirect coincident with `i_sys_ready` in HOLD (target 0x8000_0200):
  - the instruction is neither captured nor transferred;
  - the next request is to 0x8000_0200.
- Redirect in REQ while `req_ready`=1 (target 0x8000_0040):
  - `req_valid`=0 that cycle;
  - the next cycle requests 0x8000_0040.
- Wrap and reset:
  - `RESET_PC`=32'hFFFF_FFFC: after one transfer, the next request is 0x0000_0000;
  - asserting `i_sys_rst` mid-WAIT: both valids drop at once, and after release fetch restarts at `RESET_PC`.
